// File: rtl/cla_subtractor_16bit_pipe_if.sv
// cla_subtractor_16bit_pipe_if: operand/result valid-ready bus of the pipelined subtractor
interface cla_subtractor_16bit_pipe_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, bin, out_valid, out_ready, bout, ovf, zero;
  logic [WIDTH-1:0] a, b, diff;
  modport master(output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf, zero);
  modport slave(input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf, zero);
endinterface

// File: rtl/cla_subtractor_16bit_pipe.sv
// cla_subtractor_16bit_pipe: two-stage CLA subtractor, diff = a - b - bin, low half then high half
module cla_subtractor_16bit_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic clk,
  input logic rst,
  cla_subtractor_16bit_pipe_if.slave sub_if
);
  localparam int HALF = WIDTH / 2;
  function automatic logic look(input logic [HALF-1:0] g, input logic [HALF-1:0] p, input logic cin,
                                input int k, input int n);
    logic c, t;
    c = cin;
    for (int j = 0; j < n; j++) c = c & p[k+j];
    for (int j = 0; j < n; j++) begin
      t = g[k+j];
      for (int m = j + 1; m < n; m++) t = t & p[k+m];
      c = c | t;
    end
    return c;
  endfunction
  // Lookahead inside each group, group carries ripple; returns {carry_out, sum}
  function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x, input logic [HALF-1:0] y, input logic cin);
    logic [HALF-1:0] g, p, s;
    logic gc;
    g = x & y;
    p = x ^ y;
    gc = cin;
    s = '0;
    for (int k = 0; k < HALF; k += GROUP) begin
      for (int i = 0; i < GROUP; i++) s[k+i] = p[k+i] ^ look(g, p, gc, k, i);
      gc = look(g, p, gc, k, GROUP);
    end
    return {gc, s};
  endfunction
  logic s1_valid_q, s2_valid_q, s1_en, s2_en;
  logic [HALF-1:0] lo_q, a_hi_q, bn_hi_q;
  logic c_mid_q, a_msb_q, b_msb_q;
  logic [HALF:0] lo_d, hi_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic bout_q, ovf_q, zero_q, ovf_d;
  always_comb begin
    s2_en = !s2_valid_q || sub_if.out_ready;
    s1_en = !s1_valid_q || s2_en;
    lo_d = cla_half(sub_if.a[HALF-1:0], ~sub_if.b[HALF-1:0], ~sub_if.bin);
    hi_d = cla_half(a_hi_q, bn_hi_q, c_mid_q);
    diff_d = {hi_d[HALF-1:0], lo_q};
    ovf_d = (a_msb_q != b_msb_q) && (diff_d[WIDTH-1] != a_msb_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      lo_q <= '0;
      c_mid_q <= 1'b0;
      a_hi_q <= '0;
      bn_hi_q <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (s1_en) s1_valid_q <= sub_if.in_valid;
      if (s1_en && sub_if.in_valid) begin
        lo_q <= lo_d[HALF-1:0];
        c_mid_q <= lo_d[HALF];
        a_hi_q <= sub_if.a[WIDTH-1:HALF];
        bn_hi_q <= ~sub_if.b[WIDTH-1:HALF];
        a_msb_q <= sub_if.a[WIDTH-1];
        b_msb_q <= sub_if.b[WIDTH-1];
      end
      if (s2_en) s2_valid_q <= s1_valid_q;
      if (s2_en && s1_valid_q) begin
        diff_q <= diff_d;
        bout_q <= ~hi_d[HALF];
        ovf_q <= ovf_d;
        zero_q <= ~|diff_d;
      end
    end
  assign sub_if.in_ready = s1_en;
  assign sub_if.out_valid = s2_valid_q;
  assign sub_if.diff = diff_q;
  assign sub_if.bout = bout_q;
  assign sub_if.ovf = ovf_q;
  assign sub_if.zero = zero_q;
endmodule

// File: tb/tb_cla_subtractor_16bit_pipe.sv
// tb_cla_subtractor_16bit_pipe: directed vectors, stall/reset scenarios and a random stream vs a-b-bin model
module tb_cla_subtractor_16bit_pipe;
  localparam int W = 16;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  cla_subtractor_16bit_pipe_if #(.WIDTH(W)) bus();
  cla_subtractor_16bit_pipe #(.WIDTH(W), .GROUP(4)) dut(.clk(clk), .rst(rst), .sub_if(bus));
  int errors = 0, checks = 0, accepted = 0;
  logic [W+2:0] exp_q[$];
  logic [W+2:0] hand_exp, e, held;
  logic hand, stall_q;
  logic [W-1:0] corner[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
    return {r[W-1:0], r[W], (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]), r[W-1:0] == '0};
  endfunction
  function automatic logic [W-1:0] pick();
    return ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
  endfunction
  always @(negedge clk)
    if (rst) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_fields", {bus.diff, bus.bout, bus.ovf, bus.zero}, held);
      end
      stall_q = bus.out_valid && !bus.out_ready;
      held = {bus.diff, bus.bout, bus.ovf, bus.zero};
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          chk("diff", bus.diff, e[W+2:3]);
          chk("bout", bus.bout, e[2]);
          chk("ovf", bus.ovf, e[1]);
          chk("zero", bus.zero, e[0]);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(hand ? hand_exp : model(bus.a, bus.b, bus.bin));
        accepted++;
      end
    end
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                      input logic [W-1:0] d, input logic bo, input logic ov, input logic z);
    logic acc;
    bus.a = a;
    bus.b = b;
    bus.bin = bi;
    hand_exp = {d, bo, ov, z};
    bus.in_valid = 1'b1;
    for (int t = 0; t <= 200; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (t == 200) chk("send_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask
  initial begin
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.bin = 0; bus.out_ready = 1;
    hand = 1; hand_exp = 0; stall_q = 0; held = 0;
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff", bus.diff, 0);
    rst = 0;
    chk("post_rst_in_ready", bus.in_ready, 1);
    send(16'h0005, 16'h0003, 0, 16'h0002, 0, 0, 0);
    chk("latency_1", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("latency_2", bus.out_valid, 1);
    send(16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0);
    send(16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0, 0);
    send(16'h8000, 16'h0001, 0, 16'h7FFF, 0, 1, 0);
    send(16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 1, 0);
    send(16'h1234, 16'h1233, 1, 16'h0000, 0, 0, 1);
    send(16'h00FF, 16'h00FF, 0, 16'h0000, 0, 0, 1);
    drain();
    bus.out_ready = 0;
    fork
      begin
        send(16'h0010, 16'h0001, 0, 16'h000F, 0, 0, 0);
        send(16'h0100, 16'h0100, 0, 16'h0000, 0, 0, 1);
        send(16'h0001, 16'h0002, 0, 16'hFFFF, 1, 0, 0);
        send(16'hFFFF, 16'h0001, 1, 16'hFFFD, 0, 0, 0);
        send(16'h8000, 16'h7FFF, 0, 16'h0001, 0, 1, 0);
      end
      begin
        repeat (4) @(negedge clk);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        bus.out_ready = 1;
      end
    join
    drain();
    bus.out_ready = 0;
    send(16'h0009, 16'h0004, 0, 16'h0005, 0, 0, 0);
    send(16'h0003, 16'h0003, 0, 16'h0000, 0, 0, 1);
    rst = 1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_diff", bus.diff, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    chk("rel_in_ready", bus.in_ready, 1);
    bus.out_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_ghost", bus.out_valid, 0);
    send(16'h4000, 16'h0001, 1, 16'h3FFE, 0, 0, 0);
    chk("fresh_lat_1", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("fresh_lat_2", bus.out_valid, 1);
    drain();
    hand = 0;
    accepted = 0;
    for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.a = pick();
      bus.b = pick();
      bus.bin = 1'($urandom_range(0, 1));
      bus.out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    chk("random_count", 32'(accepted >= 10000), 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
